// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude datapath: one shift-add multiply step or one restoring divide step per cycle.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                div_mode,
    input  logic [XLEN-1:0]     mag_a,
    input  logic [XLEN-1:0]     mag_b,
    output logic [2*XLEN-1:0]   acc
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     upper_shift;
    logic [XLEN:0]     trial;

    // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
    always_comb begin
        add_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
        upper_shift = acc_q[2*XLEN-1:XLEN-1];
        trial       = upper_shift - {1'b0, opnd_q};
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        if (load) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
        end else if (step) begin
            if (div_mode) begin
                acc_d = trial[XLEN] ? {upper_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, operand sign handling, special cases and result select.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              load, step;
    logic              a_signed, b_signed, sa_in, sb_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] acc, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // MULHSU signs only op_a; MUL low word is sign-agnostic so it runs unsigned
    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
                || (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa_in    = a_signed & op_a[XLEN-1];
        sb_in    = b_signed & op_b[XLEN-1];
        mag_a    = sa_in ? XLEN'(-op_a) : op_a;
        mag_b    = sb_in ? XLEN'(-op_b) : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .div_mode (f3_q[2]),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .acc      (acc)
    );

    // Sign correction and result select applied in FIX
    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (2*XLEN)'(-acc) : acc;
        quo_fix  = (sa_q ^ sb_q) ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = sa_q ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
                    f3_d  = funct3;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall = 1'b1;
                step  = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                stall    = 1'b1;
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A killed op leaves the result register untouched
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and done cycle queued at issue.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model built from 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, output int lat);
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        lat = 34;
        r   = '0;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = 64'(sa * sbv); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'h0, b})); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) begin lat = 1; r = 32'hFFFF_FFFF; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lat = 1; r = a; end
                else r = 32'(sa / sbv);
            end
            3'd5: begin
                if (b == 0) begin lat = 1; r = 32'hFFFF_FFFF; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) begin lat = 1; r = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lat = 1; r = 32'h0; end
                else r = 32'(sa % sbv);
            end
            default: begin
                if (b == 0) begin lat = 1; r = a; end
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.cyc);
                check("stall_at_done", {31'd0, stall}, 32'd0);
            end
        end
    end

    // Issue in the next cycle; returns at the negedge of the done cycle (start held if hold=1)
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold);
        int unsigned t0;
        bit          got;
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        t0     = cyc;
        sb_q.push_back('{exp, 32'(t0 + lat)});
        #1 check("stall_accept", {31'd0, stall}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            check("stall_busy", {31'd0, stall}, 32'd1);
            if (!hold) start = 1'b0;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          lat;
        logic [2:0]  rf;
        logic [31:0] ra, rb, rexp;

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;

        // Main multiply / divide cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, 0);

        // Special cases
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

        // start held through DONE, next op issued back-to-back in the first IDLE cycle
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 34, 1);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 34, 1);
        run_op(3'd7, 32'd7, 32'd0, 32'd7, 1, 1);
        go_idle();

        // Flush mid-calculation, then a fresh op two cycles later
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc != t0 + 10; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 34, 0);
        go_idle();

        // flush and start together in IDLE: not accepted
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        #1 check("flush_start_stall", {31'd0, stall}, 32'd0);
        go_idle();
        repeat (2) @(negedge clk);
        check("flush_start_noaccept", {31'd0, stall}, 32'd0);

        // Reset mid-operation
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc != t0 + 5; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);

        // Random operations against the model
        for (int k = 0; k < 10; k++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rexp = model(rf, ra, rb, lat);
            run_op(rf, ra, rb, rexp, lat, 0);
        end
        go_idle();

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
